// File: rtl/teleport_controller_pkg.sv
// Shared definitions for the teleport controller.
//   - tp_state_t    : controller FSM states
//   - COORD_*       : nibble positions of the destination tile inside the
//                     8-bit coordinate byte (same layout as the teleport step tile)
//   - tile_to_px()  : tile index -> landing pixel, 11-bit unsigned arithmetic
package teleport_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_FADE_OUT = 3'd2,
    ST_MOVE     = 3'd3,
    ST_FADE_IN  = 3'd4,
    ST_COOLDOWN = 3'd5
  } tp_state_t;

  localparam int COORD_X_HI = 7;
  localparam int COORD_X_LO = 4;
  localparam int COORD_Y_HI = 3;
  localparam int COORD_Y_LO = 0;

  localparam int CNT_W = 16;

  function automatic logic [10:0] tile_to_px(input logic [3:0] idx,
                                             input int         shift,
                                             input int         offs);
    return (11'(idx) << shift) + 11'(offs);
  endfunction

endpackage

// File: rtl/teleport_controller_frame_counter.sv
// Frame counter shared by every timed state of the teleport controller.
// Ports:
//   clk, resetN  : clock, synchronous active-low reset
//   i_clear      : zero the count (wins over i_enable, so a frame pulse that
//                  coincides with a state entry is frame 0, not frame 1)
//   i_enable     : count one frame (driven by startOfFrame)
//   i_limit      : number of frames of the current state
//   o_count      : current frame index
//   o_terminal   : o_count is the last frame of the current state
module teleport_controller_frame_counter
  import teleport_controller_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == i_limit - 1'b1);

endmodule

// File: rtl/teleport_controller.sv
// Teleport sequencer: on a teleport-step collision, captures the destination
// tile, fades the player out, issues a single position load, fades back in and
// then ignores further triggers for a cooldown period.
// Ports:
//   clk, resetN          : clock, synchronous active-low reset
//   startOfFrame         : one-clk pulse per video frame
//   collision_teleport   : player overlaps a teleport step
//   teleport_cordinates  : destination tile {X[7:4], Y[3:0]}, valid 1 clk after collision
//   teleport_active      : sequence in progress (not IDLE / COOLDOWN)
//   freeze_motion        : hold player motion integration
//   fade_level           : 0 = fully visible .. 15 = invisible
//   load_position        : one-clk pulse, player jumps to new_X/new_Y
//   new_X, new_Y         : landing top-left pixel
//   bad_dest             : sticky, an out-of-range destination was captured
module teleport_controller
  import teleport_controller_pkg::*;
#(
  parameter int FADE_FRAMES     = 16,
  parameter int COOLDOWN_FRAMES = 32,
  parameter int NUM_OF_COLS     = 10,
  parameter int NUM_OF_ROWS     = 7,
  parameter int TILE_SHIFT      = 6,
  parameter int LAND_OFFSET_X   = 7,
  parameter int LAND_OFFSET_Y   = 20
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        collision_teleport,
  input  logic [7:0]  teleport_cordinates,
  output logic        teleport_active,
  output logic        freeze_motion,
  output logic [3:0]  fade_level,
  output logic        load_position,
  output logic [10:0] new_X,
  output logic [10:0] new_Y,
  output logic        bad_dest
);

  tp_state_t r_state;
  logic       r_active, r_freeze, r_load, r_bad;
  logic [3:0] r_fade;
  logic [10:0] r_new_x, r_new_y;

  logic [3:0]       w_tile_x, w_tile_y;
  logic             w_dest_ok;
  logic             w_clear, w_enable, w_terminal;
  logic [CNT_W-1:0] w_limit, w_count, w_count_inc;

  // Fade ramp 0..15 over FADE_FRAMES frames; a one-frame fade jumps straight to 15.
  function automatic logic [3:0] fade_ramp(input logic [CNT_W-1:0] c);
    logic [31:0] v;
    if (FADE_FRAMES <= 1) return 4'd15;
    v = (32'(c) * 32'd15) / 32'(FADE_FRAMES - 1);
    return (v > 32'd15) ? 4'd15 : v[3:0];
  endfunction

  assign w_tile_x  = teleport_cordinates[COORD_X_HI:COORD_X_LO];
  assign w_tile_y  = teleport_cordinates[COORD_Y_HI:COORD_Y_LO];
  assign w_dest_ok = (32'(w_tile_x) < NUM_OF_COLS) && (32'(w_tile_y) < NUM_OF_ROWS);

  // Counter is zeroed on the same edge the FSM enters a timed state.
  assign w_clear  = ((r_state == ST_CAPTURE) && w_dest_ok) ||
                    (r_state == ST_MOVE) ||
                    ((r_state == ST_FADE_IN) && startOfFrame && w_terminal);
  assign w_enable = startOfFrame && ((r_state == ST_FADE_OUT) ||
                                     (r_state == ST_FADE_IN)  ||
                                     (r_state == ST_COOLDOWN));
  assign w_limit  = (r_state == ST_COOLDOWN) ? CNT_W'(COOLDOWN_FRAMES)
                                             : CNT_W'(FADE_FRAMES);
  assign w_count_inc = w_count + 1'b1;

  teleport_controller_frame_counter u_frame_counter (
    .clk        (clk),
    .resetN     (resetN),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_limit    (w_limit),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  // Outputs are registered alongside the state, so each branch assigns the
  // output values that belong to the state being entered / frame being counted.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
      r_freeze <= 1'b0;
      r_fade   <= 4'd0;
      r_load   <= 1'b0;
      r_new_x  <= '0;
      r_new_y  <= '0;
      r_bad    <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (collision_teleport) begin
            r_state  <= ST_CAPTURE;
            r_active <= 1'b1;
            r_freeze <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (w_dest_ok) begin
            r_new_x <= tile_to_px(w_tile_x, TILE_SHIFT, LAND_OFFSET_X);
            r_new_y <= tile_to_px(w_tile_y, TILE_SHIFT, LAND_OFFSET_Y);
            r_fade  <= 4'd0;
            r_state <= ST_FADE_OUT;
          end else begin
            r_bad    <= 1'b1;
            r_active <= 1'b0;
            r_freeze <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_FADE_OUT: begin
          if (startOfFrame) begin
            if (w_terminal) begin
              r_state <= ST_MOVE;
              r_load  <= 1'b1;
              r_fade  <= 4'd15;
            end else begin
              r_fade <= fade_ramp(w_count_inc);
            end
          end
        end
        ST_MOVE: begin
          r_state <= ST_FADE_IN;
          r_fade  <= 4'd15;
        end
        ST_FADE_IN: begin
          if (startOfFrame) begin
            if (w_terminal) begin
              r_state  <= ST_COOLDOWN;
              r_fade   <= 4'd0;
              r_active <= 1'b0;
              r_freeze <= 1'b0;
            end else begin
              r_fade <= 4'd15 - fade_ramp(w_count_inc);
            end
          end
        end
        ST_COOLDOWN: begin
          if (startOfFrame && w_terminal) r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
          r_freeze <= 1'b0;
          r_fade   <= 4'd0;
        end
      endcase
    end
  end

  assign teleport_active = r_active;
  assign freeze_motion   = r_freeze;
  assign fade_level      = r_fade;
  assign load_position   = r_load;
  assign new_X           = r_new_x;
  assign new_Y           = r_new_y;
  assign bad_dest        = r_bad;

endmodule

// File: tb/tb_teleport_controller.sv
// Directed bench for teleport_controller with FADE_FRAMES=4, COOLDOWN_FRAMES=4.
module tb_teleport_controller;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        collision_teleport;
  logic [7:0]  teleport_cordinates;
  logic        teleport_active;
  logic        freeze_motion;
  logic [3:0]  fade_level;
  logic        load_position;
  logic [10:0] new_X;
  logic [10:0] new_Y;
  logic        bad_dest;

  int n_checks = 0;
  int n_errors = 0;
  int n_loads  = 0;
  int loads_ref;

  always #5 clk = ~clk;

  always @(posedge clk) if (load_position) n_loads++;

  teleport_controller #(
    .FADE_FRAMES     (4),
    .COOLDOWN_FRAMES (4)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .collision_teleport  (collision_teleport),
    .teleport_cordinates (teleport_cordinates),
    .teleport_active     (teleport_active),
    .freeze_motion       (freeze_motion),
    .fade_level          (fade_level),
    .load_position       (load_position),
    .new_X               (new_X),
    .new_Y               (new_Y),
    .bad_dest            (bad_dest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: a startOfFrame pulse followed by two quiet clocks.
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  task automatic trigger(input logic [7:0] coord);
    collision_teleport = 1'b1;
    tick();
    collision_teleport  = 1'b0;
    teleport_cordinates = coord;
    tick();
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    collision_teleport = 1'b0;
    teleport_cordinates = 8'h00;
    #1;
    tick();
    tick();

    // Reset state
    chk("rst_active", teleport_active, 0);
    chk("rst_freeze", freeze_motion, 0);
    chk("rst_fade", fade_level, 0);
    chk("rst_load", load_position, 0);
    chk("rst_newx", new_X, 0);
    chk("rst_bad", bad_dest, 0);
    resetN = 1'b1;
    tick();

    // Full sequence with destination 8'h76
    collision_teleport = 1'b1;
    tick();
    chk("cap_active_latency", teleport_active, 1);
    chk("cap_freeze", freeze_motion, 1);
    collision_teleport  = 1'b0;
    teleport_cordinates = 8'h76;
    tick();
    chk("fo_newx", new_X, 455);
    chk("fo_newy", new_Y, 404);
    chk("fo_fade0", fade_level, 0);
    loads_ref = n_loads;
    frame(); chk("fo_fade1", fade_level, 5);
    frame(); chk("fo_fade2", fade_level, 10);
    frame(); chk("fo_fade3", fade_level, 15);
    chk("fo_noload", n_loads - loads_ref, 0);
    frame();
    chk("move_one_load", n_loads - loads_ref, 1);
    chk("fi_fade0", fade_level, 15);
    chk("fi_freeze", freeze_motion, 1);
    frame(); chk("fi_fade1", fade_level, 10);
    frame(); chk("fi_fade2", fade_level, 5);
    frame(); chk("fi_fade3", fade_level, 0);
    chk("fi_active", teleport_active, 1);
    frame();
    chk("cd_active", teleport_active, 0);
    chk("cd_freeze", freeze_motion, 0);
    chk("cd_fade", fade_level, 0);
    frame(); frame(); frame();
    // Cooldown frame 3: a collision must be ignored
    collision_teleport = 1'b1;
    tick();
    collision_teleport = 1'b0;
    tick();
    chk("cd_ignore_coll", teleport_active, 0);
    // 12th frame returns to IDLE; collision on the very next clock retriggers
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("idle_after_12", teleport_active, 0);
    collision_teleport = 1'b1;
    tick();
    chk("retrigger", teleport_active, 1);
    collision_teleport  = 1'b0;
    teleport_cordinates = 8'h16;
    tick();
    chk("b_newx", new_X, 71);
    chk("b_newy", new_Y, 404);
    chk("seq_loads", n_loads - loads_ref, 1);

    // Collision held through the whole sequence
    do_reset();
    loads_ref = n_loads;
    teleport_cordinates = 8'h16;
    collision_teleport  = 1'b1;
    tick();
    tick();
    chk("hold_newx", new_X, 71);
    for (int i = 0; i < 8; i++) frame();
    chk("hold_cd_active", teleport_active, 0);
    frame(); frame(); frame();
    chk("hold_cd_still", teleport_active, 0);
    chk("hold_loads", n_loads - loads_ref, 1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("hold_idle", teleport_active, 0);
    tick();
    chk("hold_rearm", teleport_active, 1);
    collision_teleport = 1'b0;

    // Out-of-range destination
    do_reset();
    trigger(8'hA2);
    chk("bad_flag", bad_dest, 1);
    chk("bad_active", teleport_active, 0);
    chk("bad_freeze", freeze_motion, 0);
    chk("bad_newx", new_X, 0);
    tick();
    tick();
    chk("bad_sticky", bad_dest, 1);
    chk("bad_freeze_later", freeze_motion, 0);
    resetN = 1'b0;
    tick();
    chk("bad_cleared", bad_dest, 0);
    resetN = 1'b1;
    tick();

    // Reset during FADE_OUT frame 2
    trigger(8'h76);
    loads_ref = n_loads;
    frame(); frame();
    chk("mid_fade2", fade_level, 10);
    resetN = 1'b0;
    tick();
    chk("mid_rst_active", teleport_active, 0);
    chk("mid_rst_fade", fade_level, 0);
    chk("mid_rst_freeze", freeze_motion, 0);
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) frame();
    chk("mid_rst_noload", n_loads - loads_ref, 0);
    chk("mid_rst_idle", teleport_active, 0);

    // startOfFrame coincident with CAPTURE->FADE_OUT
    collision_teleport = 1'b1;
    tick();
    collision_teleport  = 1'b0;
    teleport_cordinates = 8'h76;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("coin_fade0", fade_level, 0);
    loads_ref = n_loads;
    tick();
    frame(); frame(); frame();
    chk("coin_fade3", fade_level, 15);
    chk("coin_noload", n_loads - loads_ref, 0);
    frame();
    chk("coin_load", n_loads - loads_ref, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/teleport_controller.md
TELEPORT_CONTROLLER -- requirements
Module: teleport_controller

Interface
REQ-001 Parameter FADE_FRAMES, default 16, frames spent in each of FADE_OUT and FADE_IN.
REQ-002 Parameter COOLDOWN_FRAMES, default 32, frames after landing during which new teleport triggers are ignored.
REQ-003 Parameters NUM_OF_COLS 10, NUM_OF_ROWS 7, legal tile index bounds; TILE_SHIFT 6, tile size 64 px as a shift.
REQ-004 Parameters LAND_OFFSET_X 7 and LAND_OFFSET_Y 20, landing pixel offset inside the destination tile.
REQ-005 clk  in  1  the single system clock; all logic is clocked on its rising edge.
REQ-006 resetN  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 startOfFrame  in  1  one-clk pulse per VGA frame.
REQ-008 collision_teleport  in  1  player-pixel overlaps a teleport step this clk.
REQ-009 teleport_cordinates  in  8  destination tile: [7:4] X index, [3:0] Y index; valid one clk after the matching collision.
REQ-010 teleport_active  out  1  high in every state except IDLE and COOLDOWN.
REQ-011 freeze_motion  out  1  player speed/position integration shall hold while high.
REQ-012 fade_level  out  4  player dimming level; 0 means fully visible, 15 means invisible.
REQ-013 load_position  out  1  one-clk pulse commanding the player to jump to new_X/new_Y.
REQ-014 new_X, new_Y  out  11 each  landing top-left pixel; stable from the load_position pulse until the next capture.
REQ-015 bad_dest  out  1  sticky flag: an out-of-range destination was captured.

Function
REQ-016 FSM states: IDLE, CAPTURE, FADE_OUT, MOVE, FADE_IN, COOLDOWN.
REQ-017 IDLE→CAPTURE on collision_teleport=1; collision_teleport is ignored in every other state.
REQ-018 CAPTURE lasts exactly 1 clk and latches teleport_cordinates.
- If X<NUM_OF_COLS and Y<NUM_OF_ROWS: compute new_X=(X<<TILE_SHIFT)+LAND_OFFSET_X and new_Y=(Y<<TILE_SHIFT)+LAND_OFFSET_Y, in 11-bit unsigned arithmetic; go to FADE_OUT.
- Otherwise: set bad_dest, leave new_X/new_Y unchanged, go to IDLE.
REQ-019 The frame counter clears on entry to FADE_OUT, FADE_IN and COOLDOWN, and increments only on startOfFrame.
REQ-020 FADE_OUT: fade_level = counter*15/(FADE_FRAMES-1), saturating at 15; when counter reaches FADE_FRAMES-1 on a startOfFrame, go to MOVE.
REQ-021 MOVE lasts exactly 1 clk: load_position=1, fade_level=15; then go to FADE_IN.
REQ-022 FADE_IN: fade_level = 15 - counter*15/(FADE_FRAMES-1); exit to COOLDOWN with fade_level=0.
REQ-023 COOLDOWN: exit to IDLE after COOLDOWN_FRAMES startOfFrame pulses; this prevents ping-pong between paired portals.
REQ-024 freeze_motion=1 in CAPTURE, FADE_OUT, MOVE and FADE_IN.
REQ-025 startOfFrame coincident with a state entry counts as frame 0 of that state; it is not counted twice.
REQ-026 All outputs are registered; latency from collision_teleport to teleport_active=1 is 1 clk.

Reset
REQ-027 resetN=0 forces IDLE, counter=0, and all outputs 0 (bad_dest included) on the next clk edge, including mid-sequence; in particular no load_position pulse is issued.

Structure
REQ-028 A shared package holds the FSM state enum and the coordinate nibble-field positions; the nibble fields are shared with the teleport step tile.
REQ-029 One sub-module, frame_counter (clear, enable=startOfFrame, terminal-count compare), is instantiated once and reused by all timed states.

Verification
REQ-030 Run with FADE_FRAMES=4, COOLDOWN_FRAMES=4 for fast simulation. Collision, then coordinates 8'h76 → new_X=455, new_Y=404. One load_position pulse occurs after 4 frames, with fade_level 0→15→0. IDLE is reached 12 frames after the trigger.
REQ-031 Collision held continuously through the whole sequence → exactly one teleport, exactly one load_position, no re-trigger until the cooldown ends.
REQ-032 Coordinates 8'hA2 (X=10) → bad_dest=1, no freeze_motion after CAPTURE, state returns to IDLE.
REQ-033 resetN=0 during FADE_OUT frame 2 → next clk: IDLE, fade_level=0, freeze_motion=0, and no load_position pulse afterwards.
REQ-034 startOfFrame asserted in the same clk as the CAPTURE→FADE_OUT transition → FADE_OUT still spans exactly FADE_FRAMES pulses.
REQ-035 Coordinates 8'h16 → new_X=71, new_Y=404. A second collision during COOLDOWN is ignored; a collision one clk after IDLE is re-entered starts a new sequence.
